// File: rtl/alu_exec_unit_pkg.sv
// Shared encodings for the execute-stage ALU: gout opcodes, main-control aluop
// values and the R-type funct codes that the ALU-control decoder understands.
package alu_exec_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned GOUT_W = 4;

    localparam logic [3:0] GOUT_AND  = 4'b0000;
    localparam logic [3:0] GOUT_OR   = 4'b0001;
    localparam logic [3:0] GOUT_ADD  = 4'b0010;
    localparam logic [3:0] GOUT_XOR  = 4'b0011;
    localparam logic [3:0] GOUT_NAND = 4'b0100;
    localparam logic [3:0] GOUT_SUB  = 4'b0110;
    localparam logic [3:0] GOUT_SLT  = 4'b0111;
    localparam logic [3:0] GOUT_NOR  = 4'b1100;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_NAND  = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;

    localparam logic [3:0] FUNCT_ADD = 4'b0000;
    localparam logic [3:0] FUNCT_SUB = 4'b0010;
    localparam logic [3:0] FUNCT_AND = 4'b0100;
    localparam logic [3:0] FUNCT_OR  = 4'b0101;
    localparam logic [3:0] FUNCT_XOR = 4'b0110;
    localparam logic [3:0] FUNCT_NOR = 4'b0111;
    localparam logic [3:0] FUNCT_SLT = 4'b1010;

endpackage

// File: rtl/alu_exec_unit_adder32.sv
// Plain 32-bit wrap-around adder; carry-out is dropped.
module adder32
    import alu_exec_unit_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU-control decode, 32-bit ALU with N/Z/V, PC adders and flag register.
// Define ALU_LOGIC_EXT_EN to enable the XOR/NAND/NOR operations.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        aluop,
    input  logic [3:0]        funct,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              flag_we,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] br_offset,
    output logic [GOUT_W-1:0] gout,
    output logic [DATA_W-1:0] result,
    output logic              zout,
    output logic              nflag,
    output logic              vflag,
    output logic [DATA_W-1:0] pc_plus4,
    output logic [DATA_W-1:0] br_target,
    output logic              n_q,
    output logic              z_q,
    output logic              v_q
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              add_ovf;
    logic              sub_ovf;

    // ALU-control decoder; anything not recognised falls back to ADD
    always_comb begin
        gout = GOUT_ADD;
        case (aluop)
            ALUOP_ADD: gout = GOUT_ADD;
            ALUOP_SUB: gout = GOUT_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: gout = GOUT_ADD;
                    FUNCT_SUB: gout = GOUT_SUB;
                    FUNCT_AND: gout = GOUT_AND;
                    FUNCT_OR:  gout = GOUT_OR;
                    FUNCT_SLT: gout = GOUT_SLT;
`ifdef ALU_LOGIC_EXT_EN
                    FUNCT_XOR: gout = GOUT_XOR;
                    FUNCT_NOR: gout = GOUT_NOR;
`endif
                    default:   gout = GOUT_ADD;
                endcase
            end
`ifdef ALU_LOGIC_EXT_EN
            ALUOP_NAND: gout = GOUT_NAND;
`endif
            ALUOP_OR:  gout = GOUT_OR;
            default:   gout = GOUT_ADD;
        endcase
    end

    assign sum     = a + b;
    assign diff    = a - b;
    assign add_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    assign sub_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);

    // SLT uses the overflow-corrected sign of a-b so it is right across the full range
    always_comb begin
        result = sum;
        vflag  = 1'b0;
        case (gout)
            GOUT_AND: result = a & b;
            GOUT_OR:  result = a | b;
            GOUT_ADD: begin
                result = sum;
                vflag  = add_ovf;
            end
            GOUT_SUB: begin
                result = diff;
                vflag  = sub_ovf;
            end
            GOUT_SLT: result = DATA_W'(diff[DATA_W-1] ^ sub_ovf);
`ifdef ALU_LOGIC_EXT_EN
            GOUT_XOR:  result = a ^ b;
            GOUT_NAND: result = ~(a & b);
            GOUT_NOR:  result = ~(a | b);
`endif
            default: begin
                result = sum;
                vflag  = add_ovf;
            end
        endcase
    end

    assign zout  = (result == '0);
    assign nflag = result[DATA_W-1];

    adder32 u_pc_plus4 (
        .a   (pc),
        .b   (DATA_W'(4)),
        .sum (pc_plus4)
    );

    adder32 u_br_target (
        .a   (pc_plus4),
        .b   (br_offset),
        .sum (br_target)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q <= 1'b0;
            z_q <= 1'b0;
            v_q <= 1'b0;
        end else if (flag_we) begin
            n_q <= nflag;
            z_q <= zout;
            v_q <= vflag;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed cases plus random traffic checked
// against an arithmetic reference model.
module tb_alu_exec_unit;

`ifdef ALU_LOGIC_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  aluop;
    logic [3:0]  funct;
    logic [31:0] a, b, pc, br_offset;
    logic        flag_we;
    logic [3:0]  gout;
    logic [31:0] result, pc_plus4, br_target;
    logic        zout, nflag, vflag, n_q, z_q, v_q;

    typedef struct {
        logic [3:0]  gout;
        logic [31:0] result;
        logic        z, n, v;
        logic [31:0] pc4, bt;
        logic        nq, zq, vq;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic m_n = 1'b0, m_z = 1'b0, m_v = 1'b0;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk(clk), .reset(reset), .aluop(aluop), .funct(funct), .a(a), .b(b),
        .flag_we(flag_we), .pc(pc), .br_offset(br_offset), .gout(gout),
        .result(result), .zout(zout), .nflag(nflag), .vflag(vflag),
        .pc_plus4(pc_plus4), .br_target(br_target), .n_q(n_q), .z_q(z_q), .v_q(v_q)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [3:0] model_gout(input logic [2:0] op, input logic [3:0] f);
        case (op)
            3'd1: return 4'd6;
            3'd2: case (f)
                4'd0:  return 4'd2;
                4'd2:  return 4'd6;
                4'd4:  return 4'd0;
                4'd5:  return 4'd1;
                4'd10: return 4'd7;
                4'd6:  return EXT ? 4'd3 : 4'd2;
                4'd7:  return EXT ? 4'd12 : 4'd2;
                default: return 4'd2;
            endcase
            3'd3: return EXT ? 4'd4 : 4'd2;
            3'd4: return 4'd1;
            default: return 4'd2;
        endcase
    endfunction

    // Result and overflow from signed integer arithmetic on wide values
    task automatic model_alu(input logic [3:0] g, input logic [31:0] x, input logic [31:0] y,
                             output logic [31:0] r, output logic ov);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint t;
        ov = 1'b0;
        case (g)
            4'd0:  r = x & y;
            4'd1:  r = x | y;
            4'd3:  r = x ^ y;
            4'd4:  r = ~(x & y);
            4'd12: r = ~(x | y);
            4'd7:  r = (sx < sy) ? 32'd1 : 32'd0;
            4'd6: begin
                t = sx - sy;
                r = t[31:0];
                ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            default: begin
                t = sx + sy;
                r = t[31:0];
                ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
        endcase
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] f, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] p, input logic [31:0] off,
                         input logic we);
        exp_t e;
        logic [31:0] r;
        logic ov;
        @(posedge clk);
        #1;
        aluop = op; funct = f; a = x; b = y; pc = p; br_offset = off; flag_we = we;
        e.gout = model_gout(op, f);
        model_alu(e.gout, x, y, r, ov);
        e.result = r;
        e.v  = ov;
        e.z  = (r == 32'd0);
        e.n  = r[31];
        e.pc4 = p + 32'd4;
        e.bt  = p + 32'd4 + off;
        e.nq = m_n; e.zq = m_z; e.vq = m_v;
        exp_q.push_back(e);
        if (we) begin
            m_n = e.n; m_z = e.z; m_v = e.v;
        end
    endtask

    // Monitor: the DUT presents a settled result every cycle an item was issued
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gout", 32'(gout), 32'(e.gout));
                chk("result", result, e.result);
                chk("zout", 32'(zout), 32'(e.z));
                chk("nflag", 32'(nflag), 32'(e.n));
                chk("vflag", 32'(vflag), 32'(e.v));
                chk("pc_plus4", pc_plus4, e.pc4);
                chk("br_target", br_target, e.bt);
                chk("n_q", 32'(n_q), 32'(e.nq));
                chk("z_q", 32'(z_q), 32'(e.zq));
                chk("v_q", 32'(v_q), 32'(e.vq));
            end
        end
    end

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0] fsel [8];
        fsel = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd10, 4'd6, 4'd7, 4'd15};
        reset = 1'b1; aluop = '0; funct = '0; a = '0; b = '0;
        pc = '0; br_offset = '0; flag_we = 1'b0;
        #2;
        chk("reset_n_q", 32'(n_q), 32'd0);
        chk("reset_z_q", 32'(z_q), 32'd0);
        chk("reset_v_q", 32'(v_q), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        issue(3'b010, 4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h0000_001C, 32'hFFFF_FFF0, 1'b1);
        issue(3'b001, 4'b0000, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFC, 32'h0, 1'b1);
        issue(3'b000, 4'b0000, 32'h5, 32'h6, 32'h100, 32'h8, 1'b0);

        // Asynchronous reset between edges must clear the flags at once
        @(posedge clk);
        #1 flag_we = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("async_reset_z_q", 32'(z_q), 32'd0);
        chk("async_reset_n_q", 32'(n_q), 32'd0);
        chk("async_reset_v_q", 32'(v_q), 32'd0);
        m_n = 1'b0; m_z = 1'b0; m_v = 1'b0;
        #1 reset = 1'b0;

        issue(3'b010, 4'b1010, 32'h8000_0000, 32'h1, 32'h0, 32'h0, 1'b1);
        issue(3'b011, 4'b0000, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0, 32'h0, 1'b1);
        issue(3'b010, 4'b1111, 32'h3, 32'h4, 32'h0, 32'h0, 1'b0);
        issue(3'b001, 4'b0000, 32'h8000_0000, 32'h1, 32'h0, 32'h0, 1'b1);
        issue(3'b000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            issue(3'($urandom_range(0, 7)), fsel[$urandom_range(0, 7)],
                  rand_word(), rand_word(), rand_word(), rand_word(),
                  1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d items left expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage arithmetic block of the single-cycle MIPS-style datapath. It combines three functions. The ALU-control decoder maps the 3-bit main-control ALUop and the low 4 funct bits to a 4-bit operation code. The 32-bit ALU produces the result plus zero, negative and overflow flags. Two 32-bit adders compute PC+4 and the branch target. A small clocked flag register holds N/Z/V for flag-conditioned branches (brv, baln, blezal).

## Interface
Parameters:
- none (all widths fixed at 32-bit data, 4-bit op code)

Ports:
- clk  in  1  clock; the flag register updates on rising edge
- reset  in  1  asynchronous, active-high; clears the flag register
- aluop  in  3  {aluop2,aluop1,aluop0} from the main control unit
- funct  in  4  instruction bits [3:0]
- a  in  32  operand A (register read data 1)
- b  in  32  operand B (ALUSrc mux output)
- flag_we  in  1  capture flags at the next rising edge
- pc  in  32  current program counter
- br_offset  in  32  sign-extended immediate, already shifted left 2
- gout  out  4  decoded ALU operation
- result  out  32  ALU result
- zout  out  1  result == 0
- nflag  out  1  result[31]
- vflag  out  1  signed overflow
- pc_plus4  out  32  pc + 4
- br_target  out  32  pc_plus4 + br_offset
- n_q, z_q, v_q  out  1 each  registered flags

## Operation
- ALU-control decode, aluop to gout:
  - 000 → ADD 0010 (lw/sw/addi)
  - 001 → SUB 0110 (beq)
  - 010 → R-type, decoded from funct
  - 011 → NAND 0100 (nandi)
  - 100 → OR 0001
  - 101/110/111 → ADD
- R-type funct decode:
  - 0000 ADD 0010, 0010 SUB 0110
  - 0100 AND 0000, 0101 OR 0001
  - 1010 SLT 0111, 0110 XOR 0011, 0111 NOR 1100
  - any other funct → ADD
- ALU, by gout:
  - AND a&b; OR a|b; ADD a+b; SUB a−b
  - SLT: 1 if signed a<b, computed as (a−b)[31] XOR overflow, else 0
  - XOR a^b; NAND ~(a&b); NOR ~(a|b)
  - any undefined gout → ADD
- Arithmetic is modulo 2^32; carry-out is discarded.
- vflag:
  - ADD: operands share a sign and the result sign differs.
  - SUB: operand signs differ and the result sign differs from a.
  - All other ops: 0.
- zout and nflag are derived from result for every op. For SLT, nflag is 0.
- The adders wrap modulo 2^32, e.g. pc=FFFFFFFC gives pc_plus4=00000000.

## Timing
- gout, result, zout, nflag, vflag, pc_plus4 and br_target are purely combinational with zero-cycle latency. Reset does not affect them.
- Flag register: on a rising clk with flag_we=1, n_q←nflag, z_q←zout, v_q←vflag. With flag_we=0 it holds.
- reset asserted: n_q, z_q and v_q go to 0 immediately, regardless of clk. reset dominates flag_we on a simultaneous edge.
- Reset release takes effect at the next rising edge; there is no pipelining otherwise.

## Configuration
- ALU_LOGIC_EXT_EN:
  - Defined: XOR, NAND and NOR are decoded and executed as above.
  - Undefined:
    - funct 0110/0111 and aluop 011 decode to ADD 0010.
    - gout 0011/0100/1100 execute as ADD.
    - The rest of the block is unchanged.

## Structure
- Shared package holds:
  - gout opcode constants (GOUT_AND, GOUT_OR, GOUT_ADD, GOUT_SUB, GOUT_SLT, GOUT_XOR, GOUT_NAND, GOUT_NOR)
  - aluop encodings
  - R-type funct constants
- One natural sub-module: `adder32` (a, b → a+b), instantiated twice for pc_plus4 and br_target.
- Decoder, ALU and flag register live in the top.

## Test plan
- aluop=010, funct=0000, a=7FFFFFFF, b=1 → gout=0010, result=80000000, vflag=1, nflag=1, zout=0.
- aluop=001, a=b=12345678 → gout=0110, result=0, zout=1. Then flag_we=1 at an edge → z_q=1; then assert reset between edges → z_q=0 immediately.
- aluop=010, funct=1010, a=80000000, b=1 → result=1 (signed less-than despite subtract overflow), vflag=0.
- aluop=011, a=F0F0F0F0, b=FFFF0000 → result=0F0FFFFF (NAND) with ALU_LOGIC_EXT_EN; without it → result=F0EFF0F0 (ADD).
- pc=0000001C, br_offset=FFFFFFF0 → pc_plus4=00000020, br_target=00000010.
- aluop=010, funct=1111 (undefined) → gout=0010; a=3, b=4 → result=7.
